// File: rtl/clk_monitor_if.sv
// Signal bundle between a clock monitor and its user: control, monitored clock and measurement results.
interface clk_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             clr;
    logic             mon_clk;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic             meas_valid;
    logic             too_fast;
    logic             timeout;

    modport master (
        output en, clr, mon_clk,
        input  period, high_time, low_time, meas_valid, too_fast, timeout
    );

    modport slave (
        input  en, clr, mon_clk,
        output period, high_time, low_time, meas_valid, too_fast, timeout
    );
endinterface

// File: rtl/clk_monitor.sv
// clk_monitor: measures period/high/low time of an asynchronous mon_clk in clk cycles, with sticky too_fast/timeout flags.
// Optional: define CLK_MON_GLITCH_FILTER_EN to ignore single-cycle pulses on the synchronized input.
module clk_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PERIOD  = 4,
    parameter int unsigned MAX_PHASE   = 1000
) (
    input logic          clk,
    input logic          rst_n,
    clk_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_PH  = CNT_W'(MAX_PHASE);

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_d;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       hi_cnt_nxt;
    logic [CNT_W:0]         sum;
    logic [CNT_W-1:0]       period_new;
    logic                   latch;
    logic                   phase_to;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_q;
    logic [CNT_W-1:0]       low_q;
    logic                   valid_q;
    logic                   too_fast_q;
    logic                   timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon.mon_clk};
        end
    end

    assign lvl = sync_q[SYNC_STAGES-1];

`ifdef CLK_MON_GLITCH_FILTER_EN
    logic filt_q;
    logic stable;

    // A new level is accepted only once two consecutive samples agree.
    assign stable = (lvl == lvl_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_d  <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            lvl_d <= lvl;
            if (stable) begin
                filt_q <= lvl;
            end
        end
    end

    assign rise = stable & lvl & ~filt_q;
    assign fall = stable & ~lvl & filt_q;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_cnt_nxt = hi_cnt;
        latch      = 1'b0;
        phase_to   = 1'b0;
        sum        = {1'b0, hi_cnt} + {1'b0, cnt};
        period_new = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

        if (!mon.en) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            hi_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = WAIT_RISE;
                    cnt_nxt    = '0;
                    hi_cnt_nxt = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_nxt = MEAS_HIGH;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                MEAS_HIGH: begin
                    if (cnt >= MAX_PH) begin
                        phase_to  = 1'b1;
                        state_nxt = WAIT_RISE;
                        cnt_nxt   = '0;
                    end else if (fall) begin
                        hi_cnt_nxt = cnt;
                        cnt_nxt    = CNT_ONE;
                        state_nxt  = MEAS_LOW;
                    end else begin
                        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (cnt >= MAX_PH) begin
                        phase_to  = 1'b1;
                        state_nxt = WAIT_RISE;
                        cnt_nxt   = '0;
                    end else if (rise) begin
                        // Rising edge closes this period and opens the next high phase.
                        latch     = 1'b1;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = MEAS_HIGH;
                    end else begin
                        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_cnt     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            low_q      <= '0;
            valid_q    <= 1'b0;
            too_fast_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_cnt  <= hi_cnt_nxt;
            valid_q <= latch;
            if (latch) begin
                period_q <= period_new;
                high_q   <= hi_cnt;
                low_q    <= cnt;
            end
            too_fast_q <= (latch && (32'(period_new) < MIN_PERIOD)) || (too_fast_q && !mon.clr);
            timeout_q  <= phase_to || (timeout_q && !mon.clr);
        end
    end

    assign mon.period     = period_q;
    assign mon.high_time  = high_q;
    assign mon.low_time   = low_q;
    assign mon.meas_valid = valid_q;
    assign mon.too_fast   = too_fast_q;
    assign mon.timeout    = timeout_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Self-checking bench for clk_monitor: timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_clk_monitor;

    localparam int S    = 2;
    localparam int MINP = 8;
    localparam int MAXP = 20;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    bit   chk_on;
    int   vcount;

    clk_monitor_if #(.CNT_W(16)) mif ();

    clk_monitor #(
        .CNT_W      (16),
        .SYNC_STAGES(S),
        .MIN_PERIOD (MINP),
        .MAX_PHASE  (MAXP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mon  (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: edges are timestamps of the sampled mon_clk seen S cycles later;
    // phase lengths are differences between edge times.
    typedef enum {M_OFF, M_ARMED, M_HIGH, M_LOW} mmode_t;
    mmode_t mode;
    logic   hist[$];
    logic   acc;
    int     t, t_rise, t_fall;
    int     e_period, e_high, e_low;
    logic   e_valid, e_tf, e_to;

    always @(posedge clk) begin : model
        logic a, b, chg, is_rise, is_fall, set_tf, set_to;
        int   hi, lo;
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back(1'b0);
            acc = 0; mode = M_OFF; t = 0; t_rise = 0; t_fall = 0;
            e_period = 0; e_high = 0; e_low = 0;
            e_valid = 0; e_tf = 0; e_to = 0;
        end else begin
            t++;
            a = hist[S-1];
            b = hist[S];
`ifdef CLK_MON_GLITCH_FILTER_EN
            chg = (a == b) && (a != acc);
            if (chg) acc = a;
`else
            chg = (a != b);
`endif
            is_rise = chg && a;
            is_fall = chg && !a;
            set_tf = 0; set_to = 0; e_valid = 0;
            if (!mif.en) begin
                mode = M_OFF;
            end else begin
                case (mode)
                    M_OFF:   mode = M_ARMED;
                    M_ARMED: if (is_rise) begin t_rise = t; mode = M_HIGH; end
                    M_HIGH: begin
                        if (t - t_rise >= MAXP) begin set_to = 1; mode = M_ARMED; end
                        else if (is_fall) begin t_fall = t; mode = M_LOW; end
                    end
                    M_LOW: begin
                        if (t - t_fall >= MAXP) begin set_to = 1; mode = M_ARMED; end
                        else if (is_rise) begin
                            hi = t_fall - t_rise;
                            lo = t - t_fall;
                            e_high = hi;
                            e_low = lo;
                            e_period = (hi + lo > 65535) ? 65535 : hi + lo;
                            e_valid = 1;
                            if (e_period < MINP) set_tf = 1;
                            t_rise = t;
                            mode = M_HIGH;
                        end
                    end
                endcase
            end
            e_tf = set_tf || (e_tf && !mif.clr);
            e_to = set_to || (e_to && !mif.clr);
            hist.push_front(mif.mon_clk);
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("meas_valid", mif.meas_valid, e_valid);
            cmp("period", mif.period, e_period);
            cmp("high_time", mif.high_time, e_high);
            cmp("low_time", mif.low_time, e_low);
            cmp("too_fast", mif.too_fast, e_tf);
            cmp("timeout", mif.timeout, e_to);
            if (mif.meas_valid === 1'b1) vcount++;
        end
    end

    task automatic hold(input logic v, input int cyc);
        mif.mon_clk = v;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic run_clk(input int hi, input int lo, input int n);
        repeat (n) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected test end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : stim
        int v0, vmark, tmark, seen;
        n_chk = 0; n_fail = 0; chk_on = 0; vcount = 0;
        rst_n = 0;
        mif.en = 0; mif.clr = 0; mif.mon_clk = 0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        cmp("rst_period", mif.period, 0);
        cmp("rst_high", mif.high_time, 0);
        cmp("rst_low", mif.low_time, 0);
        cmp("rst_valid", mif.meas_valid, 0);
        cmp("rst_too_fast", mif.too_fast, 0);
        cmp("rst_timeout", mif.timeout, 0);
        rst_n = 1;

        // 50% duty clock
        mif.en = 1;
        run_clk(5, 5, 8);
        cmp("sym_period", mif.period, 10);
        cmp("sym_high", mif.high_time, 5);
        cmp("sym_low", mif.low_time, 5);

        // asymmetric clock
        run_clk(3, 7, 6);
        cmp("asym_period", mif.period, 10);
        cmp("asym_high", mif.high_time, 3);
        cmp("asym_low", mif.low_time, 7);

        // stall high
        mif.mon_clk = 1;
        vmark = -1; tmark = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mif.meas_valid === 1'b1) vmark = i;
            if (mif.timeout === 1'b1 && tmark < 0) tmark = i;
        end
        cmp("stall_delay", tmark - vmark, 20);
        cmp("stall_timeout", mif.timeout, 1);
        cmp("stall_hold_period", mif.period, 10);
        mif.clr = 1;
        @(negedge clk);
        mif.clr = 0;
        cmp("timeout_clr", mif.timeout, 0);
        run_clk(5, 5, 4);

        // too fast, then clr held across violations
        run_clk(2, 2, 6);
        cmp("fast_period", mif.period, 4);
        cmp("fast_high", mif.high_time, 2);
        cmp("fast_too_fast", mif.too_fast, 1);
        mif.clr = 1;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            mif.mon_clk = ((i / 2) % 2 == 0);
            @(negedge clk);
            if (mif.meas_valid === 1'b1) begin
                seen++;
                cmp("fast_set_beats_clr", mif.too_fast, 1);
            end
        end
        mif.clr = 0;
        cmp("fast_clr_reports", (seen >= 3), 1);

        // reset during low phase
        run_clk(5, 5, 3);
        hold(1'b1, 5);
        hold(1'b0, 4);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        cmp("mid_rst_period", mif.period, 0);
        cmp("mid_rst_high", mif.high_time, 0);
        cmp("mid_rst_low", mif.low_time, 0);
        cmp("mid_rst_too_fast", mif.too_fast, 0);
        hold(1'b0, 3);
        v0 = vcount;
        run_clk(5, 5, 3);
        cmp("mid_rst_reports", vcount - v0, 2);

        // enable dropped during low phase
        run_clk(5, 5, 2);
        hold(1'b1, 5);
        hold(1'b0, 3);
        mif.en = 0;
        repeat (3) @(negedge clk);
        mif.en = 1;
        cmp("en_hold_period", mif.period, 10);
        cmp("en_hold_high", mif.high_time, 5);
        hold(1'b0, 2);
        v0 = vcount;
        run_clk(5, 5, 3);
        cmp("en_reports", vcount - v0, 2);

        // one-cycle low glitch inside a 10-cycle high phase
        run_clk(5, 5, 3);
        v0 = vcount;
        hold(1'b1, 4);
        hold(1'b0, 1);
        hold(1'b1, 5);
        hold(1'b0, 5);
        hold(1'b1, 5);
`ifdef CLK_MON_GLITCH_FILTER_EN
        cmp("glitch_reports", vcount - v0, 2);
        cmp("glitch_high", mif.high_time, 10);
`else
        cmp("glitch_reports", vcount - v0, 3);
        cmp("glitch_high", mif.high_time, 5);
`endif
        cmp("glitch_low", mif.low_time, 5);

        // randomized phases with occasional stalls, clr, enable drops and resets
        repeat (250) begin
            int hi, lo;
            hi = $urandom_range(2, 12);
            lo = $urandom_range(2, 12);
            if ($urandom_range(0, 19) == 0) hi = $urandom_range(18, 28);
            if ($urandom_range(0, 19) == 0) lo = $urandom_range(18, 28);
            mif.clr = ($urandom_range(0, 7) == 0);
            mif.mon_clk = 1;
            @(negedge clk);
            mif.clr = 0;
            repeat (hi - 1) @(negedge clk);
            hold(1'b0, lo);
            if ($urandom_range(0, 29) == 0) begin
                mif.en = 0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                mif.en = 1;
            end
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 0;
                @(negedge clk);
                rst_n = 1;
            end
        end
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
